iter_divider: RTL

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/iter_divider.sv | 89 ++++++++
 1 files changed

// File: rtl/iter_divider.sv
// iter_divider: 32-bit signed/unsigned restoring divider that produces one quotient bit per clock
module iter_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t      r_state, w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_dvd, r_bmag, r_rem, r_quo;
    logic        r_neg_q, r_neg_r, r_dz;
    logic [31:0] w_amag, w_bmag, w_rem;
    logic [32:0] w_sh;
    logic        w_ge, w_bz;
    assign w_bz   = (b == 32'd0);
    assign w_amag = (sgn && a[31]) ? -a : a;
    assign w_bmag = (sgn && b[31]) ? -b : b;
    assign w_sh   = {r_rem, r_dvd[31]};
    assign w_ge   = (w_sh >= {1'b0, r_bmag});
    assign w_rem  = w_ge ? (w_sh[31:0] - r_bmag) : w_sh[31:0];
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // Next state: a zero divisor skips the iterations and goes straight to FIN
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && start) w_next = w_bz ? FIN : RUN;
        else if (r_state == RUN && r_cnt == 6'd31) w_next = FIN;
        else if (r_state == FIN) w_next = IDLE;
    end
    // Datapath: capture operands, shift-subtract in RUN, publish sign-corrected result in FIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            r_cnt   <= 6'd0;
            r_dvd   <= 32'd0;
            r_bmag  <= 32'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    busy    <= 1'b1;
                    r_cnt   <= 6'd0;
                    r_dvd   <= w_amag;
                    r_bmag  <= w_bmag;
                    // divide-by-zero result is preloaded here so FIN handles both paths alike
                    r_rem   <= w_bz ? a : 32'd0;
                    r_quo   <= w_bz ? 32'hFFFF_FFFF : 32'd0;
                    r_dz    <= w_bz;
                    r_neg_q <= sgn && (a[31] ^ b[31]) && !w_bz;
                    r_neg_r <= sgn && a[31] && !w_bz;
                end
                RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_dvd <= {r_dvd[30:0], 1'b0};
                    r_rem <= w_rem;
                    r_quo <= {r_quo[30:0], w_ge};
                end
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    div0 <= r_dz;
                    lo   <= r_neg_q ? -r_quo : r_quo;
                    hi   <= r_neg_r ? -r_rem : r_rem;
                end
                default: ;
            endcase
        end
    end
endmodule
